// File: rtl/enigma_pkg.sv
// Shared Enigma datapath types and helpers: alphabet constants, wiring table, slicing.
// No latency (types and pure functions only); no backpressure.
package enigma_pkg;

    localparam int LETTERS = 26;
    localparam int CW = 8;
    localparam logic [CW-1:0] ASCII_A = 8'h41;
    localparam logic [CW-1:0] ASCII_Z = 8'h5A;

    typedef logic [LETTERS-1:0][CW-1:0] table_t;

    function automatic logic is_letter(input logic [CW-1:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

    // The first character of the wiring string sits in the MSBs of the flat bus.
    function automatic table_t unpack_table(input logic [LETTERS*CW-1:0] idx);
        table_t t;
        for (int k = 0; k < LETTERS; k++) begin
            t[k] = idx[LETTERS*CW-1-CW*k -: CW];
        end
        return t;
    endfunction

endpackage

// File: rtl/enigma_fifo2.sv
// Generic 2-entry valid/ready buffer with synchronous flush.
// Latency 1 cycle from push to o_vld; i_rdy feeds o_rdy combinationally.
// Backpressure: o_rdy low only when full and the head is not being taken.
module enigma_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    input  logic         i_rdy
);

    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;

    assign o_vld  = (r_cnt != 2'd0);
    assign o_dat  = r_d0;
    assign o_rdy  = (r_cnt != 2'd2) || i_rdy;
    assign w_push = i_vld && o_rdy;
    assign w_pop  = o_vld && i_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else if (i_flush) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_d0 <= i_dat;
                    else               r_d1 <= i_dat;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: count holds, new data lands behind the survivor.
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_dat;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/enigma_reflector.sv
// Enigma reflector: maps letters through a loadable table into a 2-entry output buffer.
// Latency 1 cycle din->dout; in_ready drops when full and out_ready is low, or when not in RUN.
// ENIGMA_REFLECTOR_CHECK_EN adds a 26-cycle post-load legality scan and the sticky err flag.
module enigma_reflector
    import enigma_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set,
    input  logic [LETTERS*CW-1:0] idx_in,
    input  logic                  valid,
    input  logic [CW-1:0]         din,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         dout,
    output logic                  table_ok,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, CHECK, RUN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    table_t        r_table;
    logic          w_fifo_rdy;
    logic          w_push;
    logic [CW-1:0] w_din_off;
    logic [CW-1:0] w_map;

    assign w_din_off = din - ASCII_A;
    assign w_map     = is_letter(din) ? r_table[w_din_off[4:0]] : din;
    assign in_ready  = (r_state == RUN) && w_fifo_rdy;
    assign w_push    = valid && (r_state == RUN) && !set;
    assign table_ok  = (r_state == RUN);

`ifdef ENIGMA_REFLECTOR_CHECK_EN
    logic [4:0]    r_idx;
    logic          r_err;
    logic [CW-1:0] w_ent;
    logic [CW-1:0] w_ent_off;
    logic [CW-1:0] w_self;
    logic          w_fail;

    // Entry must be a letter, not self-mapped, and point back at its own slot.
    assign w_ent     = r_table[r_idx];
    assign w_ent_off = w_ent - ASCII_A;
    assign w_self    = ASCII_A + {3'b000, r_idx};
    assign w_fail    = !is_letter(w_ent) || (w_ent == w_self) ||
                       (r_table[w_ent_off[4:0]] != w_self);
    assign err       = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 5'd0;
            r_err <= 1'b0;
        end else if (set) begin
            r_idx <= 5'd0;
            r_err <= 1'b0;
        end else if (r_state == CHECK) begin
            r_idx <= r_idx + 5'd1;
            if (w_fail) r_err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (set) begin
`ifdef ENIGMA_REFLECTOR_CHECK_EN
            w_state_nxt = CHECK;
`else
            w_state_nxt = RUN;
`endif
        end
`ifdef ENIGMA_REFLECTOR_CHECK_EN
        else if (r_state == CHECK) begin
            if (w_fail)                    w_state_nxt = IDLE;
            else if (r_idx == 5'(LETTERS-1)) w_state_nxt = RUN;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_table <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (set) r_table <= unpack_table(idx_in);
        end
    end

    enigma_fifo2 #(.W(CW)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_flush (set),
        .i_vld   (w_push),
        .i_dat   (w_map),
        .o_rdy   (w_fifo_rdy),
        .o_vld   (out_valid),
        .o_dat   (dout),
        .i_rdy   (out_ready)
    );

endmodule

// File: tb/tb_enigma_reflector.sv
// Directed bench for enigma_reflector with hand-computed expectations (reflector B wiring).
module tb_enigma_reflector;

    logic         clk = 1'b0;
    logic         reset;
    logic         set;
    logic [207:0] idx_in;
    logic         valid;
    logic [7:0]   din;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   dout;
    logic         table_ok;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [207:0] tbl_b   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    logic [207:0] tbl_bad = "ARUHQSLDPXNGOKMIEBFZCWVJAT";
    logic [31:0]  s_in    = "ABCZ";
    logic [31:0]  s_out   = "YRUT";

`ifdef ENIGMA_REFLECTOR_CHECK_EN
    localparam int LOAD_LAT = 26;
`else
    localparam int LOAD_LAT = 0;
`endif

    enigma_reflector dut (
        .clk       (clk),
        .reset     (reset),
        .set       (set),
        .idx_in    (idx_in),
        .valid     (valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .table_ok  (table_ok),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse set with a table, then count edges until table_ok (bounded).
    task automatic load(input logic [207:0] t, output int n);
        set    = 1'b1;
        idx_in = t;
        tick();
        set = 1'b0;
        n = 0;
        while (!table_ok && !err && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_dout"},      32'(dout),      32'h00);
        chk({tag, "_table_ok"},  32'(table_ok),  32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; set = 1'b0; idx_in = '0; valid = 1'b0; din = 8'h00; out_ready = 1'b1;
        tick(); tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        load(tbl_b, n);
        chk("load_lat", 32'(n), 32'(LOAD_LAT));
        chk("load_ok", 32'(table_ok), 32'd1);
        chk("load_err", 32'(err), 32'd0);

        valid = 1'b1; din = "A";
        #1 chk("a_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("a_vld", 32'(out_valid), 32'd1);
        chk("a_dout", 32'(dout), 32'("Y"));
        din = "Y";
        tick();
        chk("y_dout", 32'(dout), 32'("A"));
        valid = 1'b0;
        tick();
        chk("drain_vld", 32'(out_valid), 32'd0);

        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; din = s_in[31-8*i -: 8];
            #1 chk("stream_rdy", 32'(in_ready), 32'd1);
            tick();
            chk("stream_vld", 32'(out_valid), 32'd1);
            chk("stream_dout", 32'(dout), 32'(s_out[31-8*i -: 8]));
        end
        valid = 1'b0;
        tick();

        out_ready = 1'b0; valid = 1'b1; din = "A";
        tick();
        din = "B";
        tick();
        din = "C";
        #1 chk("full_rdy", 32'(in_ready), 32'd0);
        chk("full_dout", 32'(dout), 32'("Y"));
        tick();
        chk("hold_dout", 32'(dout), 32'("Y"));
        out_ready = 1'b1;
        #1 chk("pp_rdy", 32'(in_ready), 32'd1);
        tick();
        valid = 1'b0;
        chk("pp_vld", 32'(out_valid), 32'd1);
        chk("pp_dout1", 32'(dout), 32'("R"));
        tick();
        chk("pp_dout2", 32'(dout), 32'("U"));
        tick();
        chk("pp_empty", 32'(out_valid), 32'd0);

        valid = 1'b1; din = 8'h20;
        tick();
        valid = 1'b0;
        chk("space_dout", 32'(dout), 32'h20);
        tick();

        load(tbl_bad, n);
`ifdef ENIGMA_REFLECTOR_CHECK_EN
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_ok", 32'(table_ok), 32'd0);
        chk("bad_rdy", 32'(in_ready), 32'd0);
`else
        chk("bad_err", 32'(err), 32'd0);
        chk("bad_ok", 32'(table_ok), 32'd1);
        valid = 1'b1; din = "A";
        tick();
        valid = 1'b0;
        chk("bad_map", 32'(dout), 32'("A"));
        tick();
`endif
        load(tbl_b, n);
        chk("reload_lat", 32'(n), 32'(LOAD_LAT));
        chk("reload_err", 32'(err), 32'd0);

        out_ready = 1'b0; valid = 1'b1; din = "Z";
        tick();
        tick();
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        chk("pre_rst_dout", 32'(dout), 32'("T"));
        reset = 1'b1;
        #1 chk_reset_outputs("midrst");
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("post_rst_rdy", 32'(in_ready), 32'd0);
        chk("post_rst_vld", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
